// File: rtl/shifter_pkg.sv
// Shared definitions for the iterative shift/extend unit: op codes, FSM states, amount width.
// ITER_SHIFT_ROT_EN (optional) makes OP_ROR a legal rotate-right; otherwise it is an illegal op.
package shifter_pkg;

    typedef logic [2:0] op_t;

    localparam op_t OP_SLL      = 3'b000;
    localparam op_t OP_SRL      = 3'b001;
    localparam op_t OP_SRA      = 3'b010;
    localparam op_t OP_SEXT_SLL = 3'b011;
    localparam op_t OP_ZEXT_SLL = 3'b100;
    localparam op_t OP_ROR      = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    function automatic int amt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/iter_shift_ext_shift_step.sv
// One combinational shift step of up to STEP bits; the FSM applies it once per SHIFT cycle.
// ITER_SHIFT_ROT_EN adds the rotate-right path for OP_ROR.
module shift_step
    import shifter_pkg::*;
#(
    parameter int W    = 32,
    parameter int STEP = 4,
    localparam int KW  = $clog2(STEP) + 1
) (
    input  logic [W-1:0]  data_i,
    input  op_t           op_i,
    input  logic [KW-1:0] k_i,
    output logic [W-1:0]  data_o
);

    always_comb begin
        data_o = data_i;
        case (op_i)
            OP_SLL, OP_SEXT_SLL, OP_ZEXT_SLL: data_o = data_i << k_i;
            OP_SRL:                           data_o = data_i >> k_i;
            // The sign bit never changes under >>>, so repeated steps keep filling with the original MSB.
            OP_SRA:                           data_o = W'($signed(data_i) >>> k_i);
`ifdef ITER_SHIFT_ROT_EN
            OP_ROR:                           data_o = (data_i >> k_i) | (data_i << (W - int'(k_i)));
`endif
            default:                          data_o = data_i;
        endcase
    end

endmodule

// File: rtl/iter_shift_ext.sv
// Multi-cycle shift/extend unit with valid/ready handshakes; shifts at most STEP bits per cycle.
// ITER_SHIFT_ROT_EN enables op 101 (rotate right); without it op 101 is flagged illegal.
module iter_shift_ext
    import shifter_pkg::*;
#(
    parameter int W     = 32,
    parameter int IMM_W = 16,
    parameter int STEP  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  op_t                     in_op,
    input  logic [W-1:0]            in_data,
    input  logic [amt_width(W)-1:0] in_amt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_data,
    output logic                    out_err
);

    localparam int AW = amt_width(W);
    localparam int KW = $clog2(STEP) + 1;

    state_t         state_q, state_d;
    op_t            op_q, op_d;
    logic [AW-1:0]  rem_q, rem_d;
    logic [W-1:0]   work_q, work_d;
    logic           err_q, err_d;
    logic [KW-1:0]  k;
    logic [W-1:0]   step_out;

    function automatic logic op_legal(input op_t op);
`ifdef ITER_SHIFT_ROT_EN
        return op <= OP_ROR;
`else
        return op <= OP_ZEXT_SLL;
`endif
    endfunction

    always_comb begin
        if (int'(rem_q) >= STEP) k = KW'(STEP);
        else                     k = KW'(rem_q);
    end

    shift_step #(.W(W), .STEP(STEP)) u_step (
        .data_i (work_q),
        .op_i   (op_q),
        .k_i    (k),
        .data_o (step_out)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rem_d   = rem_q;
        work_d  = work_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d  = in_op;
                    rem_d = in_amt;
                    err_d = 1'b0;
                    case (in_op)
                        OP_SEXT_SLL: work_d = {{(W-IMM_W){in_data[IMM_W-1]}}, in_data[IMM_W-1:0]};
                        OP_ZEXT_SLL: work_d = {{(W-IMM_W){1'b0}}, in_data[IMM_W-1:0]};
                        default:     work_d = in_data;
                    endcase
                    if (!op_legal(in_op)) begin
                        work_d  = in_data;
                        err_d   = 1'b1;
                        rem_d   = '0;
                        state_d = ST_DONE;
                    end else if (in_amt == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = step_out;
                rem_d  = rem_q - AW'(k);
                if (int'(rem_q) <= STEP) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_SLL;
            rem_q   <= '0;
            work_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = work_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_iter_shift_ext.sv
// Self-checking bench for iter_shift_ext: directed cases from the plan plus randomized ops
// compared against a one-shot arithmetic model (respects ITER_SHIFT_ROT_EN when defined).
module tb_iter_shift_ext;

    localparam int W     = 32;
    localparam int IMM_W = 16;
    localparam int STEP  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic [31:0] in_data = 32'd0;
    logic [4:0]  in_amt = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_err;

    always #5 clk = ~clk;

    iter_shift_ext #(.W(W), .IMM_W(IMM_W), .STEP(STEP)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Whole-operation reference: result in one arithmetic step, error flag in bit 32.
    function automatic logic [32:0] model(input logic [2:0] op, input logic [31:0] d, input int amt);
        logic [31:0] s;
        logic [31:0] z;
        s = {{16{d[15]}}, d[15:0]};
        z = {16'h0000, d[15:0]};
        case (op)
            3'd0: return {1'b0, d << amt};
            3'd1: return {1'b0, d >> amt};
            3'd2: return {1'b0, 32'($signed(d) >>> amt)};
            3'd3: return {1'b0, s << amt};
            3'd4: return {1'b0, z << amt};
`ifdef ITER_SHIFT_ROT_EN
            3'd5: return {1'b0, (d >> amt) | (d << (32 - amt))};
`endif
            default: return {1'b1, d};
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input int amt);
        logic [32:0] m;
        m = model(op, 32'd0, 0);
        if (m[32] || amt == 0) return 1;
        return 1 + (amt + STEP - 1) / STEP;
    endfunction

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic        prev_valid = 1'b0;
    int          last_lat = 0;
    int          last_acc = 0;
    int          last_hs = 0;
    logic [31:0] last_data = 32'd0;
    logic        last_err = 1'b0;

    always @(negedge clk) begin
        logic [32:0] m;
        exp_t        e;
        if (rst) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_data",  64'(out_data),  64'd0);
            chk("rst_out_err",   64'(out_err),   64'd0);
            chk("rst_in_ready",  64'(in_ready),  64'd0);
            q.delete();
            prev_valid = 1'b0;
        end else begin
            chk("in_ready", 64'(in_ready), 64'(q.size() == 0));
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("valid_without_request", 64'(out_valid), 64'd0);
                end else begin
                    chk("out_data", 64'(out_data), 64'(q[0].data));
                    chk("out_err",  64'(out_err),  64'(q[0].err));
                    if (!prev_valid) begin
                        chk("latency", 64'(cyc - q[0].acc + 1), 64'(q[0].lat));
                        last_lat  = cyc - q[0].acc + 1;
                        last_data = out_data;
                        last_err  = out_err;
                    end
                    if (out_ready) begin
                        void'(q.pop_front());
                        last_hs = cyc + 1;
                    end
                end
            end
            if (in_valid && in_ready) begin
                m = model(in_op, in_data, int'(in_amt));
                e.data = m[31:0];
                e.err  = m[32];
                e.lat  = model_lat(in_op, int'(in_amt));
                e.acc  = cyc + 1;
                q.push_back(e);
                last_acc = cyc + 1;
            end
            prev_valid = out_valid;
        end
    end

    task automatic wait_accept();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        chk("accept_timeout", 64'(got), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result_ack(input int bp);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = out_valid;
        end
        chk("result_timeout", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        repeat (bp) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] d, input logic [4:0] amt, input int bp);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_amt   = amt;
        wait_accept();
        in_valid = 1'b0;
        in_op    = 3'($urandom);
        in_data  = $urandom;
        in_amt   = 5'($urandom);
        wait_result_ack(bp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pin the model to hand-computed values.
        chk("model_sext_sll", 64'(model(3'd3, 32'h0000FFFC, 2)), {31'd0, 1'b0, 32'hFFFFFFF0});
        chk("model_sra31",    64'(model(3'd2, 32'h80000000, 31)), {31'd0, 1'b0, 32'hFFFFFFFF});
        chk("model_lat31",    64'(model_lat(3'd1, 31)), 64'd9);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_op(3'd3, 32'h0000FFFC, 5'd2, 0);
        chk("sext_sll_data", 64'(last_data), 64'hFFFFFFF0);
        chk("sext_sll_lat",  64'(last_lat),  64'd2);
        chk("sext_sll_err",  64'(last_err),  64'd0);

        run_op(3'd2, 32'h80000000, 5'd31, 1);
        chk("sra31_data", 64'(last_data), 64'hFFFFFFFF);
        chk("sra31_lat",  64'(last_lat),  64'd9);

        run_op(3'd1, 32'h80000000, 5'd31, 0);
        chk("srl31_data", 64'(last_data), 64'h00000001);
        chk("srl31_lat",  64'(last_lat),  64'd9);

        run_op(3'd0, 32'h12345678, 5'd0, 0);
        chk("sll0_data", 64'(last_data), 64'h12345678);
        chk("sll0_lat",  64'(last_lat),  64'd1);

        run_op(3'd4, 32'hFFFF8000, 5'd4, 2);
        chk("zext_sll_data", 64'(last_data), 64'h00080000);

        run_op(3'd5, 32'h00000001, 5'd1, 0);
`ifdef ITER_SHIFT_ROT_EN
        chk("ror_data", 64'(last_data), 64'h80000000);
        chk("ror_lat",  64'(last_lat),  64'd2);
        chk("ror_err",  64'(last_err),  64'd0);
`else
        chk("ror_data", 64'(last_data), 64'h00000001);
        chk("ror_lat",  64'(last_lat),  64'd1);
        chk("ror_err",  64'(last_err),  64'd1);
`endif

        run_op(3'd7, 32'hDEADBEEF, 5'd9, 0);
        chk("op111_err",  64'(last_err),  64'd1);
        chk("op111_data", 64'(last_data), 64'hDEADBEEF);
        chk("op111_lat",  64'(last_lat),  64'd1);

        // Back-pressure with a waiting request held on the input.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_data  = 32'h00000001;
        in_amt   = 5'd3;
        wait_accept();
        in_op   = 3'd1;
        in_data = 32'h000000F0;
        in_amt  = 5'd4;
        wait_result_ack(5);
        wait_accept();
        in_valid = 1'b0;
        chk("bp_accept_delay", 64'(last_acc - last_hs), 64'd1);
        wait_result_ack(0);
        chk("bp_second_data", 64'(last_data), 64'h0000000F);

        // Reset in the middle of a long shift.
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = 3'd0;
        in_data  = 32'h12345678;
        in_amt   = 5'd28;
        wait_accept();
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data",  64'(out_data),  64'd0);
        chk("midrst_in_ready",  64'(in_ready),  64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("postrst_in_ready", 64'(in_ready), 64'd1);
        run_op(3'd1, 32'h000000F0, 5'd4, 0);
        chk("postrst_srl_data", 64'(last_data), 64'h0000000F);

        for (int n = 0; n < 150; n++) begin
            run_op(3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)),
                   int'($urandom_range(0, 3)));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iter_shift_ext.md
Name: iter_shift_ext

Overview:
- Parametrised, multi-cycle shift/extend unit for the MIPS datapath.
- Generalises the fixed left-shift-by-2, sign-extend and adder helpers into one block.
- Operations: logical and arithmetic shifts by a variable amount, and sign or zero extension of an immediate followed by a left shift (branch-offset formation).
- Uses a valid/ready handshake so the EX stage can stall on it; shifts at most STEP bit positions per cycle to keep the critical path short.

Parameters:
- W, 32, datapath width in bits (≥8, power of two).
- IMM_W, 16, immediate width used by the extend ops (<W).
- STEP, 4, maximum bit positions shifted per cycle (power of two, 1..W).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- in_op  in  3  operation code (encodings in package).
- in_data  in  W  operand.
- in_amt  in  $clog2(W)  shift amount, 0..W-1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  W  result.
- out_err  out  1  illegal op flag; qualified by out_valid.

Behaviour:
- Reset is asynchronous and active-high; one clock domain.
- Reset values: state=IDLE, out_valid=0, out_data=0, out_err=0, internal remaining count=0.
  - in_ready is forced to 0 while rst=1, and is 1 in IDLE afterwards.
- Op encodings:
  - 000 SLL
  - 001 SRL
  - 010 SRA
  - 011 SEXT_SLL: sign-extend in_data[IMM_W-1:0] to W, then shift left.
  - 100 ZEXT_SLL: zero-extend in_data[IMM_W-1:0] to W, then shift left.
  - 101 ROR: optional, see below.
  - All other codes are illegal.
- FSM has three states: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). Accept = in_valid && in_ready.
- IDLE:
  - On accept, register op and amt.
  - Load the working register with the operand, already extended for ops 011/100.
  - Clear out_err.
  - Go to DONE if amt==0 or the op is illegal; otherwise go to SHIFT.
  - For an illegal op: working register = in_data unmodified, out_err=1.
- SHIFT, each cycle:
  - k = min(STEP, rem); shift the working register by k; rem -= k.
  - When rem==k before the update, go to DONE.
  - SRA fills vacated bits with the original bit W-1; SRL, SLL and the extend ops fill with 0.
- DONE:
  - out_valid=1; out_data and out_err hold the final values and stay stable while out_ready=0.
  - When out_ready=1, go to IDLE and drop out_valid the following cycle.
- Latency from the accept edge T: out_valid rises at T+1+ceil(amt/STEP). amt=0 gives T+1.
- Throughput: at most one operation per 2 cycles. No accept occurs in the same cycle as a DONE handshake.
- in_data, in_op and in_amt are sampled only at accept; later changes are ignored.
- in_valid while busy is ignored; the requester must hold it, per the standard valid/ready rule.
- Reset mid-operation: the operation is abandoned immediately, outputs take their reset values, and no result is emitted.
- All arithmetic is modulo W bits; no carry or overflow output.

Optional Feature:
- Macro: ITER_SHIFT_ROT_EN.
- Defined: op 101 = rotate right by amt. Bits leaving bit 0 re-enter at bit W-1, at k bits per step. Latency matches the other shifts. out_err=0.
- Undefined: op 101 is illegal. Result = operand unmodified, out_err=1, latency 1 cycle.
- No other behaviour differs between the two builds.

Decomposition:
- Package shifter_pkg holds:
  - op encoding constants, including OP_ROR;
  - the op typedef (3-bit);
  - a function returning the amount width as $clog2(W).
- One sub-module, shift_step: combinational; takes the working register, op and k (≤STEP) and returns the register shifted one step. Instantiated once by the FSM.

Test Plan (W=32, IMM_W=16, STEP=4):
- SEXT_SLL, data=0x0000FFFC, amt=2 -> out_data=0xFFFFFFF0, out_valid at T+2, out_err=0.
- SRA 0x80000000 by 31 -> 0xFFFFFFFF at T+9; SRL of the same operand by 31 -> 0x00000001 at T+9.
- SLL 0x12345678 by 0 -> 0x12345678 at T+1. ZEXT_SLL 0xFFFF8000 by 4 -> 0x00080000.
- Back-pressure: out_ready=0 for 5 cycles in DONE -> out_data stable and in_ready=0 throughout. A new in_valid during that time is not accepted until 1 cycle after out_ready=1.
- Reset mid-operation: assert rst 3 cycles into SLL by 28 -> out_valid=0 and out_data=0 immediately. After rst deasserts, in_ready=1 and a fresh SRL 0xF0 by 4 returns 0x0F.
- Op 101 with data=0x00000001, amt=1:
  - with ITER_SHIFT_ROT_EN -> 0x80000000 at T+2, out_err=0;
  - without it -> 0x00000001 at T+1, out_err=1.
  - Op 111 -> out_err=1 in both builds.
